regfile_writeback: RTL and testbench



---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_writeback_wb_fifo.sv | 82 ++++++++
 rtl/regfile_writeback.sv | 138 +++++++++++++
 tb/tb_regfile_writeback.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

    localparam int REG_COUNT = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_DATA_W = 8;

    // Register that receives the secondary (overflow) result.
    localparam logic [RF_ADDR_W-1:0] OVER_REG = 3'd7;

    // One completed result waiting to be written back.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] dest;
        logic [RF_DATA_W-1:0] data;
        logic                 over_flag;
        logic [RF_DATA_W-1:0] over;
    } wb_entry_t;

    // Registers an entry will write: its destination, plus r7 when the overflow flag is set.
    function automatic logic [REG_COUNT-1:0] entry_mask(input wb_entry_t e);
        logic [REG_COUNT-1:0] m;
        m = '0;
        m[e.dest] = 1'b1;
        if (e.over_flag) begin
            m[OVER_REG] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// In-order queue of write-back entries. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  wb_entry_t                  entry_i,
    input  logic                       pop_i,
    output wb_entry_t                  head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [DEPTH-1:0]           valid_o,
    output wb_entry_t [DEPTH-1:0]      slots_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic                  do_push;
    logic                  do_pop;

    // Full when the pointers address the same slot but sit on different laps.
    assign full_o  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {IDX_W{1'b0}}};
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign slots_o = mem_q;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = entry_i;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // A slot holds a live entry when its distance from the head is below the count.
    always_comb begin
        logic [IDX_W-1:0] slot_off;
        slot_off = '0;
        valid_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off   = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
            valid_o[i] = ({1'b0, slot_off} < count_o);
        end
    end

    // Pointer registers; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: stale slots are masked by valid_o.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the 8x8 register file: queues completed results,
// drains one per cycle onto the single write port and publishes a pending
// mask for read-after-write hazard stalls. DATA_W/ADDR_W must match the
// entry layout in regfile_pkg.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [ADDR_W-1:0]      dest_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   overFlag_i,
    input  logic [DATA_W-1:0]      over_i,
    input  logic                   hold_i,
    output logic                   writeFlag_o,
    output logic [ADDR_W-1:0]      destReg_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   overFlag_o,
    output logic [DATA_W-1:0]      over_o,
    output logic [REG_COUNT-1:0]   pending_o,
    output logic [$clog2(DEPTH):0] count_o
);

    wb_entry_t             in_entry;
    wb_entry_t             head;
    wb_entry_t             presented;
    wb_entry_t [DEPTH-1:0] fifo_slots;
    logic [DEPTH-1:0]      fifo_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic                  write_flag_q, write_flag_d;
    logic                  over_flag_q,  over_flag_d;
    logic [ADDR_W-1:0]     dest_q,       dest_d;
    logic [DATA_W-1:0]     data_q,       data_d;
    logic [DATA_W-1:0]     over_q,       over_d;
    logic [REG_COUNT-1:0]  pending_mask;

    // Ready depends only on queue state and reset, never on valid_i.
    assign ready_o = !fifo_full && !rst;
    assign push    = valid_i && ready_o;
    assign pop     = !fifo_empty && !hold_i;

    // Pack the incoming result for the queue.
    always_comb begin
        in_entry.dest      = dest_i;
        in_entry.data      = data_i;
        in_entry.over_flag = overFlag_i;
        in_entry.over      = over_i;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .entry_i (in_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o),
        .valid_o (fifo_valid),
        .slots_o (fifo_slots)
    );

    // Next output-port value: a pop loads the head; otherwise only the enables drop.
    always_comb begin
        write_flag_d = 1'b0;
        over_flag_d  = 1'b0;
        dest_d       = dest_q;
        data_d       = data_q;
        over_d       = over_q;
        if (pop) begin
            write_flag_d = 1'b1;
            over_flag_d  = head.over_flag;
            dest_d       = head.dest;
            data_d       = head.data;
            over_d       = head.over;
        end
    end

    // Register-file write port register.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_flag_q <= 1'b0;
            over_flag_q  <= 1'b0;
            dest_q       <= '0;
            data_q       <= '0;
            over_q       <= '0;
        end else begin
            write_flag_q <= write_flag_d;
            over_flag_q  <= over_flag_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
            over_q       <= over_d;
        end
    end

    assign writeFlag_o = write_flag_q;
    assign overFlag_o  = over_flag_q;
    assign destReg_o   = dest_q;
    assign data_o      = data_q;
    assign over_o      = over_q;

    // The entry being presented still counts as pending until the edge after its write lands.
    always_comb begin
        presented.dest      = dest_q;
        presented.data      = data_q;
        presented.over_flag = over_flag_q;
        presented.over      = over_q;
    end

    // Pending mask: every live queue entry plus the presented entry while enabled.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending_mask = pending_mask | entry_mask(fifo_slots[i]);
            end
        end
        if (write_flag_q) begin
            pending_mask = pending_mask | entry_mask(presented);
        end
    end

    assign pending_o = pending_mask;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue-level model.
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [2:0] dest_i = '0;
    logic [7:0] data_i = '0;
    logic       overFlag_i = 1'b0;
    logic [7:0] over_i = '0;
    logic       hold_i = 1'b0;
    logic       writeFlag_o;
    logic [2:0] destReg_o;
    logic [7:0] data_o;
    logic       overFlag_o;
    logic [7:0] over_o;
    logic [7:0] pending_o;
    logic [2:0] count_o;

    regfile_writeback #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .dest_i      (dest_i),
        .data_i      (data_i),
        .overFlag_i  (overFlag_i),
        .over_i      (over_i),
        .hold_i      (hold_i),
        .writeFlag_o (writeFlag_o),
        .destReg_o   (destReg_o),
        .data_o      (data_o),
        .overFlag_o  (overFlag_o),
        .over_o      (over_o),
        .pending_o   (pending_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] d;
        logic [7:0] v;
        logic       f;
        logic [7:0] o;
    } ent_t;

    ent_t       mq[$];
    logic       pres_wf = 1'b0;
    logic       pres_of = 1'b0;
    logic [2:0] pres_d = '0;
    logic [7:0] pres_v = '0;
    logic [7:0] pres_o = '0;
    logic [7:0] rf_exp [8];
    logic [7:0] rf_dut [8];

    int checks = 0;
    int errors = 0;
    int pulses;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Register file behind the write port: dest first, r7 overflow wins.
    always @(negedge clk) begin
        if (writeFlag_o === 1'b1) begin
            rf_dut[destReg_o] = data_o;
            if (overFlag_o === 1'b1) rf_dut[7] = over_o;
        end
    end

    function automatic logic [7:0] exp_pending();
        logic [7:0] p;
        p = '0;
        foreach (mq[i]) begin
            p[mq[i].d] = 1'b1;
            if (mq[i].f) p[7] = 1'b1;
        end
        if (pres_wf) begin
            p[pres_d] = 1'b1;
            if (pres_of) p[7] = 1'b1;
        end
        return p;
    endfunction

    // One clock cycle: drive inputs, advance the model, compare every output.
    task automatic step(input bit r, input bit v, input logic [2:0] d, input logic [7:0] x,
                        input bit f, input logic [7:0] o, input bit h);
        ent_t e;
        bit   exp_ready;
        bit   acc;
        bit   popq;
        @(negedge clk);
        rst = r; valid_i = v; dest_i = d; data_i = x; overFlag_i = f; over_i = o; hold_i = h;
        #1;
        exp_ready = !r && (mq.size() < DEPTH);
        chk("ready", ready_o, exp_ready);
        if (r) begin
            mq.delete();
            pres_wf = 0; pres_of = 0; pres_d = 0; pres_v = 0; pres_o = 0;
        end else begin
            acc  = v && exp_ready;
            popq = (mq.size() > 0) && !h;
            if (popq) begin
                e = mq.pop_front();
                pres_wf = 1; pres_of = e.f; pres_d = e.d; pres_v = e.v; pres_o = e.o;
                rf_exp[e.d] = e.v;
                if (e.f) rf_exp[7] = e.o;
            end else begin
                pres_wf = 0; pres_of = 0;
            end
            if (acc) begin
                e.d = d; e.v = x; e.f = f; e.o = o;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("writeFlag", writeFlag_o, pres_wf);
        chk("overFlag", overFlag_o, pres_of);
        chk("destReg", destReg_o, pres_d);
        chk("data", data_o, pres_v);
        chk("over", over_o, pres_o);
        chk("count", count_o, mq.size());
        chk("pending", pending_o, exp_pending());
        if (writeFlag_o === 1'b1) pulses++;
    endtask

    task automatic idle(input int n, input bit h);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 8'h00, 0, 8'h00, h);
    endtask

    task automatic check_rf();
        for (int k = 0; k < 8; k++) chk($sformatf("rf%0d", k), rf_dut[k], rf_exp[k]);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            rf_exp[k] = '0;
            rf_dut[k] = '0;
        end

        // reset, ready low throughout
        step(1, 1, 3'd1, 8'h11, 0, 8'h00, 0);
        step(1, 1, 3'd1, 8'h11, 0, 8'h00, 0);

        // single write to r2
        step(0, 1, 3'd2, 8'h5A, 0, 8'h00, 0);
        idle(3, 0);
        check_rf();

        // overflow write: r3 and r7
        step(0, 1, 3'd3, 8'hFF, 1, 8'h01, 0);
        idle(3, 0);
        check_rf();

        // fill under hold, 5th entry waits for the first pop
        for (int i = 0; i < 5; i++) step(0, 1, 3'(i), 8'h30 + 8'(i), 0, 8'h00, 1);
        step(0, 1, 3'd4, 8'h34, 0, 8'h00, 0);
        step(0, 1, 3'd4, 8'h34, 0, 8'h00, 0);
        idle(6, 0);
        check_rf();

        // same-register hazard on r5
        step(0, 1, 3'd5, 8'h10, 0, 8'h00, 0);
        step(0, 1, 3'd5, 8'h20, 0, 8'h00, 0);
        idle(4, 0);
        check_rf();

        // reset with three entries queued
        for (int i = 0; i < 3; i++) step(0, 1, 3'd6, 8'h60 + 8'(i), 1, 8'h70 + 8'(i), 1);
        step(1, 0, 3'd0, 8'h00, 0, 8'h00, 1);
        idle(4, 0);
        check_rf();

        // streaming 20 entries
        pulses = 0;
        for (int i = 0; i < 20; i++) step(0, 1, 3'($urandom_range(0, 7)), 8'($urandom), 0, 8'h00, 0);
        idle(2, 0);
        chk("stream_pulses", pulses, 20);
        check_rf();

        // random traffic with hold and occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 7),
                 3'($urandom_range(0, 7)),
                 8'($urandom),
                 ($urandom_range(0, 9) < 3),
                 8'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        idle(8, 0);
        check_rf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
